// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, FSM state encoding and control-word type
// shared by the control unit and the datapath bench.
package cpu_pkg;

   typedef logic [4:0] opcode_t;

   localparam opcode_t OP_LD   = 5'b00000;
   localparam opcode_t OP_LDI  = 5'b00001;
   localparam opcode_t OP_ST   = 5'b00010;
   localparam opcode_t OP_ADD  = 5'b00011;
   localparam opcode_t OP_SUB  = 5'b00100;
   localparam opcode_t OP_SHR  = 5'b00101;
   localparam opcode_t OP_SHL  = 5'b00110;
   localparam opcode_t OP_ROR  = 5'b00111;
   localparam opcode_t OP_ROL  = 5'b01000;
   localparam opcode_t OP_AND  = 5'b01001;
   localparam opcode_t OP_OR   = 5'b01010;
   localparam opcode_t OP_ADDI = 5'b01011;
   localparam opcode_t OP_ANDI = 5'b01100;
   localparam opcode_t OP_ORI  = 5'b01101;
   localparam opcode_t OP_MUL  = 5'b01110;
   localparam opcode_t OP_DIV  = 5'b01111;
   localparam opcode_t OP_NEG  = 5'b10000;
   localparam opcode_t OP_NOT  = 5'b10001;
   localparam opcode_t OP_BR   = 5'b10010;
   localparam opcode_t OP_JR   = 5'b10011;
   localparam opcode_t OP_IN   = 5'b10101;
   localparam opcode_t OP_OUT  = 5'b10110;
   localparam opcode_t OP_MFHI = 5'b10111;
   localparam opcode_t OP_MFLO = 5'b11000;
   localparam opcode_t OP_NOP  = 5'b11001;
   localparam opcode_t OP_HALT = 5'b11010;

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_FETCH0 = 4'd1,
      ST_FETCH1 = 4'd2,
      ST_FETCH2 = 4'd3,
      ST_T3     = 4'd4,
      ST_T4     = 4'd5,
      ST_T5     = 4'd6,
      ST_T6     = 4'd7,
      ST_T7     = 4'd8,
      ST_HALT   = 4'd9
   } state_e;

   typedef enum logic [3:0] {
      CL_NOP,
      CL_ALU,
      CL_IMM,
      CL_MULDIV,
      CL_UNARY,
      CL_LD,
      CL_LDI,
      CL_ST,
      CL_BR,
      CL_JR,
      CL_IN,
      CL_OUT,
      CL_MFHI,
      CL_MFLO,
      CL_HALT
   } op_class_e;

   typedef struct packed {
      logic run;
      logic pc_out;
      logic zlo_out;
      logic zhi_out;
      logic mdr_out;
      logic hi_out;
      logic lo_out;
      logic c_out;
      logic inport_out;
      logic pc_enable;
      logic pc_increment;
      logic ir_enable;
      logic mar_enable;
      logic mdr_enable;
      logic mdr_read;
      logic y_enable;
      logic zlo_enable;
      logic zhi_enable;
      logic hi_enable;
      logic lo_enable;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic ba_out;
      logic ram_enable;
      logic con_enable;
      logic outport_enable;
      logic inport_enable;
   } ctrl_t;

   // Groups opcodes that share one micro-sequence; undefined codes act as nop.
   function automatic op_class_e op_class(input opcode_t op);
      op_class_e c;
      c = CL_NOP;
      if (op >= OP_ADD && op <= OP_OR)
         c = CL_ALU;
      else if (op >= OP_ADDI && op <= OP_ORI)
         c = CL_IMM;
      else if (op == OP_MUL || op == OP_DIV)
         c = CL_MULDIV;
      else if (op == OP_NEG || op == OP_NOT)
         c = CL_UNARY;
      else if (op == OP_LD)
         c = CL_LD;
      else if (op == OP_LDI)
         c = CL_LDI;
      else if (op == OP_ST)
         c = CL_ST;
      else if (op == OP_BR)
         c = CL_BR;
      else if (op == OP_JR)
         c = CL_JR;
      else if (op == OP_IN)
         c = CL_IN;
      else if (op == OP_OUT)
         c = CL_OUT;
      else if (op == OP_MFHI)
         c = CL_MFHI;
      else if (op == OP_MFLO)
         c = CL_MFLO;
      else if (op == OP_HALT)
         c = CL_HALT;
      return c;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: datapath <-> control unit signal bundle.
// master is the control unit side, slave the datapath side.
interface control_unit_if;
   import cpu_pkg::*;

   opcode_t opcode;
   logic    con_out;
   logic    stop;

   logic run;
   logic pc_out;
   logic zlo_out;
   logic zhi_out;
   logic mdr_out;
   logic hi_out;
   logic lo_out;
   logic c_out;
   logic inport_out;
   logic pc_enable;
   logic pc_increment;
   logic ir_enable;
   logic mar_enable;
   logic mdr_enable;
   logic mdr_read;
   logic y_enable;
   logic zlo_enable;
   logic zhi_enable;
   logic hi_enable;
   logic lo_enable;
   logic gra;
   logic grb;
   logic grc;
   logic r_in;
   logic r_out;
   logic ba_out;
   logic ram_enable;
   logic con_enable;
   logic outport_enable;
   logic inport_enable;

   modport master (
      input  opcode, con_out, stop,
      output run,
      output pc_out, zlo_out, zhi_out, mdr_out,
      output hi_out, lo_out, c_out, inport_out,
      output pc_enable, pc_increment, ir_enable,
      output mar_enable, mdr_enable, mdr_read,
      output y_enable, zlo_enable, zhi_enable,
      output hi_enable, lo_enable,
      output gra, grb, grc, r_in, r_out, ba_out,
      output ram_enable, con_enable,
      output outport_enable, inport_enable
   );

   modport slave (
      output opcode, con_out, stop,
      input  run,
      input  pc_out, zlo_out, zhi_out, mdr_out,
      input  hi_out, lo_out, c_out, inport_out,
      input  pc_enable, pc_increment, ir_enable,
      input  mar_enable, mdr_enable, mdr_read,
      input  y_enable, zlo_enable, zhi_enable,
      input  hi_enable, lo_enable,
      input  gra, grb, grc, r_in, r_out, ba_out,
      input  ram_enable, con_enable,
      input  outport_enable, inport_enable
   );

endinterface

// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the multi-cycle CPU, driving
// bus selects and load strobes from the current T-state.
module control_unit
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          clr,
   control_unit_if.master bus
);

   state_e    state_q;
   state_e    state_d;
   op_class_e cls;
   ctrl_t     c;

   assign cls = op_class(bus.opcode);

   // State register; clr low forces RESET at once, killing any strobe.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         state_q <= ST_RESET;
      else
         state_q <= state_d;
   end

   // Next-state and control-word decode of the current T-state.
   always_comb begin
      state_d = state_q;
      c       = '0;
      c.run   = (state_q != ST_RESET) && (state_q != ST_HALT);
      unique case (state_q)
         ST_RESET: state_d = ST_FETCH0;
         ST_FETCH0: begin
            if (bus.stop) begin
               state_d = ST_HALT;
            end else begin
               c.pc_out       = 1'b1;
               c.mar_enable   = 1'b1;
               c.pc_increment = 1'b1;
               state_d        = ST_FETCH1;
            end
         end
         ST_FETCH1: begin
            c.mdr_read   = 1'b1;
            c.mdr_enable = 1'b1;
            state_d      = ST_FETCH2;
         end
         ST_FETCH2: begin
            c.mdr_out   = 1'b1;
            c.ir_enable = 1'b1;
            state_d     = ST_T3;
         end
         ST_T3: begin
            state_d = ST_T4;
            unique case (cls)
               CL_ALU, CL_IMM, CL_MULDIV: begin
                  c.grb      = 1'b1;
                  c.r_out    = 1'b1;
                  c.y_enable = 1'b1;
               end
               CL_UNARY: begin
                  c.grb        = 1'b1;
                  c.r_out      = 1'b1;
                  c.zlo_enable = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  c.grb      = 1'b1;
                  c.ba_out   = 1'b1;
                  c.r_out    = 1'b1;
                  c.y_enable = 1'b1;
               end
               CL_BR: begin
                  c.gra        = 1'b1;
                  c.r_out      = 1'b1;
                  c.con_enable = 1'b1;
               end
               CL_JR: begin
                  c.gra       = 1'b1;
                  c.r_out     = 1'b1;
                  c.pc_enable = 1'b1;
                  state_d     = ST_FETCH0;
               end
               CL_IN: begin
                  c.inport_out = 1'b1;
                  c.gra        = 1'b1;
                  c.r_in       = 1'b1;
                  state_d      = ST_FETCH0;
               end
               CL_OUT: begin
                  c.gra            = 1'b1;
                  c.r_out          = 1'b1;
                  c.outport_enable = 1'b1;
                  state_d          = ST_FETCH0;
               end
               CL_MFHI: begin
                  c.hi_out = 1'b1;
                  c.gra    = 1'b1;
                  c.r_in   = 1'b1;
                  state_d  = ST_FETCH0;
               end
               CL_MFLO: begin
                  c.lo_out = 1'b1;
                  c.gra    = 1'b1;
                  c.r_in   = 1'b1;
                  state_d  = ST_FETCH0;
               end
               CL_HALT: state_d = ST_HALT;
               default: state_d = ST_FETCH0;
            endcase
         end
         ST_T4: begin
            state_d = ST_T5;
            unique case (cls)
               CL_ALU: begin
                  c.grc        = 1'b1;
                  c.r_out      = 1'b1;
                  c.zlo_enable = 1'b1;
               end
               CL_IMM, CL_LD, CL_LDI, CL_ST: begin
                  c.c_out      = 1'b1;
                  c.zlo_enable = 1'b1;
               end
               CL_MULDIV: begin
                  c.grc        = 1'b1;
                  c.r_out      = 1'b1;
                  c.zlo_enable = 1'b1;
                  c.zhi_enable = 1'b1;
               end
               CL_UNARY: begin
                  c.zlo_out = 1'b1;
                  c.gra     = 1'b1;
                  c.r_in    = 1'b1;
                  state_d   = ST_FETCH0;
               end
               CL_BR: begin
                  c.pc_out   = 1'b1;
                  c.y_enable = 1'b1;
               end
               default: state_d = ST_FETCH0;
            endcase
         end
         ST_T5: begin
            state_d = ST_FETCH0;
            unique case (cls)
               CL_ALU, CL_IMM, CL_LDI: begin
                  c.zlo_out = 1'b1;
                  c.gra     = 1'b1;
                  c.r_in    = 1'b1;
               end
               CL_MULDIV: begin
                  c.zlo_out   = 1'b1;
                  c.lo_enable = 1'b1;
                  state_d     = ST_T6;
               end
               CL_LD, CL_ST: begin
                  c.zlo_out    = 1'b1;
                  c.mar_enable = 1'b1;
                  state_d      = ST_T6;
               end
               CL_BR: begin
                  c.c_out      = 1'b1;
                  c.zlo_enable = 1'b1;
                  state_d      = ST_T6;
               end
               default: state_d = ST_FETCH0;
            endcase
         end
         ST_T6: begin
            state_d = ST_FETCH0;
            unique case (cls)
               CL_MULDIV: begin
                  c.zhi_out   = 1'b1;
                  c.hi_enable = 1'b1;
               end
               CL_LD: begin
                  c.mdr_read   = 1'b1;
                  c.mdr_enable = 1'b1;
                  state_d      = ST_T7;
               end
               CL_ST: begin
                  c.gra        = 1'b1;
                  c.r_out      = 1'b1;
                  c.mdr_enable = 1'b1;
                  state_d      = ST_T7;
               end
               CL_BR: begin
                  c.zlo_out   = 1'b1;
                  c.pc_enable = bus.con_out;
               end
               default: state_d = ST_FETCH0;
            endcase
         end
         ST_T7: begin
            state_d = ST_FETCH0;
            unique case (cls)
               CL_LD: begin
                  c.mdr_out = 1'b1;
                  c.gra     = 1'b1;
                  c.r_in    = 1'b1;
               end
               CL_ST: c.ram_enable = 1'b1;
               default: state_d = ST_FETCH0;
            endcase
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RESET;
      endcase
   end

   assign bus.run            = c.run;
   assign bus.pc_out         = c.pc_out;
   assign bus.zlo_out        = c.zlo_out;
   assign bus.zhi_out        = c.zhi_out;
   assign bus.mdr_out        = c.mdr_out;
   assign bus.hi_out         = c.hi_out;
   assign bus.lo_out         = c.lo_out;
   assign bus.c_out          = c.c_out;
   assign bus.inport_out     = c.inport_out;
   assign bus.pc_enable      = c.pc_enable;
   assign bus.pc_increment   = c.pc_increment;
   assign bus.ir_enable      = c.ir_enable;
   assign bus.mar_enable     = c.mar_enable;
   assign bus.mdr_enable     = c.mdr_enable;
   assign bus.mdr_read       = c.mdr_read;
   assign bus.y_enable       = c.y_enable;
   assign bus.zlo_enable     = c.zlo_enable;
   assign bus.zhi_enable     = c.zhi_enable;
   assign bus.hi_enable      = c.hi_enable;
   assign bus.lo_enable      = c.lo_enable;
   assign bus.gra            = c.gra;
   assign bus.grb            = c.grb;
   assign bus.grc            = c.grc;
   assign bus.r_in           = c.r_in;
   assign bus.r_out          = c.r_out;
   assign bus.ba_out         = c.ba_out;
   assign bus.ram_enable     = c.ram_enable;
   assign bus.con_enable     = c.con_enable;
   assign bus.outport_enable = c.outport_enable;
   assign bus.inport_enable  = c.inport_enable;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit,
// expected control words come from a per-instruction step table.
module tb_control_unit;

   typedef logic [29:0] vec_t;

   localparam vec_t RUN     = 30'd1 << 29;
   localparam vec_t PC_OUT  = 30'd1 << 28;
   localparam vec_t ZLO_OUT = 30'd1 << 27;
   localparam vec_t ZHI_OUT = 30'd1 << 26;
   localparam vec_t MDR_OUT = 30'd1 << 25;
   localparam vec_t HI_OUT  = 30'd1 << 24;
   localparam vec_t LO_OUT  = 30'd1 << 23;
   localparam vec_t C_OUT   = 30'd1 << 22;
   localparam vec_t INP_OUT = 30'd1 << 21;
   localparam vec_t PC_EN   = 30'd1 << 20;
   localparam vec_t PC_INC  = 30'd1 << 19;
   localparam vec_t IR_EN   = 30'd1 << 18;
   localparam vec_t MAR_EN  = 30'd1 << 17;
   localparam vec_t MDR_EN  = 30'd1 << 16;
   localparam vec_t MDR_RD  = 30'd1 << 15;
   localparam vec_t Y_EN    = 30'd1 << 14;
   localparam vec_t ZLO_EN  = 30'd1 << 13;
   localparam vec_t ZHI_EN  = 30'd1 << 12;
   localparam vec_t HI_EN   = 30'd1 << 11;
   localparam vec_t LO_EN   = 30'd1 << 10;
   localparam vec_t GRA     = 30'd1 << 9;
   localparam vec_t GRB     = 30'd1 << 8;
   localparam vec_t GRC     = 30'd1 << 7;
   localparam vec_t R_IN    = 30'd1 << 6;
   localparam vec_t R_OUT   = 30'd1 << 5;
   localparam vec_t BA_OUT  = 30'd1 << 4;
   localparam vec_t RAM_EN  = 30'd1 << 3;
   localparam vec_t CON_EN  = 30'd1 << 2;
   localparam vec_t OUTP_EN = 30'd1 << 1;
   localparam vec_t INP_EN  = 30'd1 << 0;

   logic clk;
   logic clr;

   control_unit_if bus ();

   control_unit dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.master)
   );

   vec_t act;
   assign act = {
      bus.run, bus.pc_out, bus.zlo_out, bus.zhi_out,
      bus.mdr_out, bus.hi_out, bus.lo_out, bus.c_out,
      bus.inport_out, bus.pc_enable, bus.pc_increment,
      bus.ir_enable, bus.mar_enable, bus.mdr_enable,
      bus.mdr_read, bus.y_enable, bus.zlo_enable,
      bus.zhi_enable, bus.hi_enable, bus.lo_enable,
      bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out,
      bus.ba_out, bus.ram_enable, bus.con_enable,
      bus.outport_enable, bus.inport_enable
   };

   vec_t exp_q[$];
   vec_t seq[$];
   int   tests = 0;
   int   fails = 0;
   int   step  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control words, one per cycle, for a whole instruction.
   function automatic void model(input int op, input bit con);
      seq = {};
      seq.push_back(RUN | PC_OUT | MAR_EN | PC_INC);
      seq.push_back(RUN | MDR_RD | MDR_EN);
      seq.push_back(RUN | MDR_OUT | IR_EN);
      if (op >= 3 && op <= 10) begin
         seq.push_back(RUN | GRB | R_OUT | Y_EN);
         seq.push_back(RUN | GRC | R_OUT | ZLO_EN);
         seq.push_back(RUN | ZLO_OUT | GRA | R_IN);
      end else if (op >= 11 && op <= 13) begin
         seq.push_back(RUN | GRB | R_OUT | Y_EN);
         seq.push_back(RUN | C_OUT | ZLO_EN);
         seq.push_back(RUN | ZLO_OUT | GRA | R_IN);
      end else if (op == 14 || op == 15) begin
         seq.push_back(RUN | GRB | R_OUT | Y_EN);
         seq.push_back(RUN | GRC | R_OUT | ZLO_EN | ZHI_EN);
         seq.push_back(RUN | ZLO_OUT | LO_EN);
         seq.push_back(RUN | ZHI_OUT | HI_EN);
      end else if (op == 16 || op == 17) begin
         seq.push_back(RUN | GRB | R_OUT | ZLO_EN);
         seq.push_back(RUN | ZLO_OUT | GRA | R_IN);
      end else if (op <= 2) begin
         seq.push_back(RUN | GRB | BA_OUT | R_OUT | Y_EN);
         seq.push_back(RUN | C_OUT | ZLO_EN);
         if (op == 1) begin
            seq.push_back(RUN | ZLO_OUT | GRA | R_IN);
         end else if (op == 0) begin
            seq.push_back(RUN | ZLO_OUT | MAR_EN);
            seq.push_back(RUN | MDR_RD | MDR_EN);
            seq.push_back(RUN | MDR_OUT | GRA | R_IN);
         end else begin
            seq.push_back(RUN | ZLO_OUT | MAR_EN);
            seq.push_back(RUN | GRA | R_OUT | MDR_EN);
            seq.push_back(RUN | RAM_EN);
         end
      end else if (op == 18) begin
         seq.push_back(RUN | GRA | R_OUT | CON_EN);
         seq.push_back(RUN | PC_OUT | Y_EN);
         seq.push_back(RUN | C_OUT | ZLO_EN);
         seq.push_back(RUN | ZLO_OUT | (con ? PC_EN : 30'd0));
      end else if (op == 19) begin
         seq.push_back(RUN | GRA | R_OUT | PC_EN);
      end else if (op == 21) begin
         seq.push_back(RUN | INP_OUT | GRA | R_IN);
      end else if (op == 22) begin
         seq.push_back(RUN | GRA | R_OUT | OUTP_EN);
      end else if (op == 23) begin
         seq.push_back(RUN | HI_OUT | GRA | R_IN);
      end else if (op == 24) begin
         seq.push_back(RUN | LO_OUT | GRA | R_IN);
      end else begin
         seq.push_back(RUN);
      end
   endfunction

   // Monitor: one expected control word per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t e;
         e = exp_q.pop_front();
         tests++;
         if (act !== e) begin
            fails++;
            $display("FAIL step%0d op=%0d got=%h exp=%h",
                     step, bus.opcode, act, e);
         end
         step++;
      end
   end

   // Called at posedge+1; leaves the DUT entering FETCH0.
   task automatic do_reset();
      clr = 1'b0;
      bus.stop = 1'b0;
      exp_q.push_back(30'd0);
      @(posedge clk); #1;
      clr = 1'b1;
      exp_q.push_back(30'd0);
      @(posedge clk); #1;
   endtask

   task automatic issue(input int op, input bit con);
      int n;
      model(op, con);
      n = seq.size();
      bus.opcode  = 5'(op);
      bus.con_out = con;
      foreach (seq[i]) exp_q.push_back(seq[i]);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.stop = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   endtask

   task automatic ld_reset();
      model(0, 1'b0);
      bus.opcode  = 5'd0;
      bus.con_out = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(seq[i]);
      repeat (4) begin
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   task automatic halt_stop();
      bus.stop = 1'b1;
      exp_q.push_back(RUN);
      @(posedge clk); #1;
      bus.stop = 1'b0;
      repeat (20) exp_q.push_back(30'd0);
      repeat (20) begin
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   task automatic halt_op();
      model(26, 1'b0);
      bus.opcode = 5'd26;
      foreach (seq[i]) exp_q.push_back(seq[i]);
      repeat (20) exp_q.push_back(30'd0);
      repeat (seq.size() + 20) begin
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   initial begin
      int op;
      clr = 1'b0;
      bus.opcode = 5'd0;
      bus.con_out = 1'b0;
      bus.stop = 1'b0;
      @(posedge clk); #1;
      do_reset();
      issue(3, 1'b0);
      issue(2, 1'b0);
      issue(18, 1'b0);
      issue(18, 1'b1);
      issue(14, 1'b0);
      ld_reset();
      halt_stop();
      halt_op();
      issue(1, 1'b1);
      for (int k = 0; k < 80; k++) begin
         op = int'($urandom_range(0, 31));
         if (op == 26) op = 25;
         issue(op, 1'($urandom_range(0, 1)));
      end
      @(negedge clk); #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain left=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; all opcode and state encodings come from the shared package.
REQ-002 clk  input  1  rising-edge clock shared with the datapath.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  5  IR[31:27] as decoded by the datapath select/encode logic.
REQ-005 con_out  input  1  branch condition flip-flop output from the datapath.
REQ-006 stop  input  1  external halt request, sampled only in FETCH0.
REQ-007 run  output  1  high while executing, low in RESET and HALT.
REQ-008 pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out, c_out, inport_out  output  1 each  bus-drive selects.
REQ-009 pc_enable, pc_increment, ir_enable, mar_enable, mdr_enable, mdr_read, y_enable, zlo_enable, zhi_enable, hi_enable, lo_enable  output  1 each  register load strobes.
REQ-010 gra, grb, grc, r_in, r_out, ba_out  output  1 each  register-field select and GPR in/out strobes.
REQ-011 ram_enable, con_enable, outport_enable, inport_enable  output  1 each  RAM write, condition-FF load, and port strobes.

Function
REQ-012 The block SHALL be a Moore FSM; every output SHALL be a pure decode of the current state, with 0 as the default.
REQ-013 The states SHALL be RESET, FETCH0, FETCH1, FETCH2, T3 through T7, and HALT.
REQ-014 Fetch sequence:
- FETCH0: pc_out, mar_enable, pc_increment.
- FETCH1: mdr_read, mdr_enable.
- FETCH2: mdr_out, ir_enable.
- Then T3.
REQ-015 In FETCH0 with stop=1, the next state SHALL be HALT, and no fetch strobes SHALL assert in that cycle.
REQ-016 Opcodes 00011-01010 (add, sub, shr, shl, ror, rol, and, or):
- T3: grb, r_out, y_enable.
- T4: grc, r_out, zlo_enable.
- T5: zlo_out, gra, r_in.
- Then FETCH0.
REQ-017 Opcodes 01011-01101 (addi, andi, ori) SHALL follow REQ-016, except that T4 asserts c_out in place of grc and r_out.
REQ-018 Opcodes 01110-01111 (mul, div):
- T3: grb, r_out, y_enable.
- T4: grc, r_out, zlo_enable, zhi_enable.
- T5: zlo_out, lo_enable.
- T6: zhi_out, hi_enable.
REQ-019 Opcodes 10000-10001 (neg, not):
- T3: grb, r_out, zlo_enable.
- T4: zlo_out, gra, r_in.
REQ-020 Opcodes ld/ldi/st (00000/00001/00010):
- T3: grb, ba_out, r_out, y_enable.
- T4: c_out, zlo_enable.
- ldi T5: zlo_out, gra, r_in.
- ld T5: zlo_out, mar_enable. T6: mdr_read, mdr_enable. T7: mdr_out, gra, r_in.
- st T5: as ld T5. T6: gra, r_out, mdr_enable with mdr_read=0. T7: ram_enable.
REQ-021 Branch (10010):
- T3: gra, r_out, con_enable.
- T4: pc_out, y_enable.
- T5: c_out, zlo_enable.
- T6: zlo_out, plus pc_enable only if con_out=1 in that cycle.
REQ-022 jr (10011): T3 asserts gra, r_out, pc_enable.
REQ-023 in (10101): T3 asserts inport_out, gra, r_in.
REQ-024 out (10110): T3 asserts gra, r_out, outport_enable.
REQ-025 mfhi/mflo (10111/11000): T3 asserts hi_out (or lo_out), gra, r_in.
REQ-026 nop (11001) and every undefined opcode SHALL go T3 to FETCH0 with no strobes asserted.
REQ-027 halt (11010) SHALL go T3 to HALT.
REQ-028 Each instruction's last T-state SHALL transition to FETCH0; at most one bus-drive select SHALL be high in any state.
REQ-029 HALT SHALL be absorbing: all outputs 0, exit only via clr.

Reset
REQ-030 While clr=0, the state SHALL be RESET and every output SHALL be 0, regardless of clk; this SHALL also hold mid-instruction, with no partial strobe completing.
REQ-031 The first rising clk edge with clr=1 SHALL move RESET to FETCH0, and run SHALL be 1 from that cycle.

Structure
REQ-032 Opcode constants and the state encoding SHALL live in a shared package, cpu_pkg, reused by the datapath bench.
REQ-033 The block SHALL be a single module with no sub-modules; a separate state register plus next-state/output decode is sufficient.

Verification
REQ-034 Scenario: release clr, hold stop=0, opcode=00011 -> states FETCH0, FETCH1, FETCH2, T3, T4, T5, FETCH0 over 6 clocks; r_in and gra high only in T5.
REQ-035 Scenario: opcode=00010 (st) -> ram_enable high exactly one cycle (T7), with mdr_read=0 in T6; instruction length 8 cycles.
REQ-036 Scenario: opcode=10010 with con_out=0, then repeat with con_out=1 -> pc_enable low in T6, then high in T6.
REQ-037 Scenario: opcode=01110 -> lo_enable in T5 and hi_enable in T6, with zlo_out/zhi_out never high together.
REQ-038 Scenario: drive clr low during T4 of ld -> all outputs 0 immediately (asynchronous); after release, FETCH0 on the next edge.
REQ-039 Scenario: stop=1 at FETCH0, and separately opcode=11010 -> HALT, run=0, outputs 0 for 20 further clocks.
